interrupt_sequencer: RTL and testbench

Sequences exception and interrupt entry/return for the CP0 register file. Arbitrates between synchronous exceptions (illegal instruction, syscall) and eight external interrupt lines, and stalls the pipeline at an instruction boundary. Drives the CP0 write strobes (EPC, Cause, interrupt-enable), then redirects fetch to the handler vector. On `eret` it re-enables interrupts and redirects fetch to the saved EPC.

---
 rtl/cp0_pkg.sv | 19 +
 rtl/irq_sync_edge.sv | 26 ++
 rtl/interrupt_sequencer.sv | 149 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: cause codes, Enable register bit positions and the
// trap sequencer state encoding.
package cp0_pkg;

  localparam logic [4:0] CAUSE_ILL      = 5'd10;
  localparam logic [4:0] CAUSE_SYS      = 5'd8;
  localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

  localparam int unsigned INT_GIE      = 0;
  localparam int unsigned INT_MASK_LSB = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StVector,
    StEret
  } seq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, followed by a
// single-cycle rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Exception/interrupt entry and eret sequencer driving the CP0 write strobes
// and the fetch redirect.
module interrupt_sequencer
  import cp0_pkg::*;
#(
  parameter int unsigned NIRQ = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_i,
  input  logic            pc_valid_i,
  input  logic [31:0]     pc_i,
  input  logic            ill_exc_i,
  input  logic            sys_exc_i,
  input  logic            eret_i,
  input  logic [31:0]     int_en_i,
  input  logic [31:0]     base_i,
  input  logic [31:0]     epc_i,
  output logic            write_epc_o,
  output logic            write_cause_o,
  output logic            write_int_o,
  output logic [31:0]     epc_pc_o,
  output logic [4:0]      cause_o,
  output logic [31:0]     int_en_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [31:0]     redirect_pc_o,
  output logic            busy_o
);

  localparam int unsigned IdxW = $clog2(NIRQ);

  seq_state_e state_q, state_d;

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] eligible;
  logic [NIRQ-1:0] clr_mask;
  logic [IdxW-1:0] irq_idx;
  logic            exc;
  logic            irq_any;
  logic [4:0]      sel_cause;
  logic            capture;

  logic [31:0] epc_q;
  logic [4:0]  cause_q;
  logic [31:0] int_en_q;

  for (genvar n = 0; n < NIRQ; n++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (irq_i[n]),
      .edge_o (irq_edge[n])
    );
  end

  assign exc      = ill_exc_i | sys_exc_i;
  assign eligible = pending_q & {NIRQ{int_en_i[INT_GIE]}} & int_en_i[INT_MASK_LSB +: NIRQ];
  assign irq_any  = |eligible;

  always_comb begin
    irq_idx = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) irq_idx = IdxW'(i);
    end
  end

  always_comb begin
    if (ill_exc_i)      sel_cause = CAUSE_ILL;
    else if (sys_exc_i) sel_cause = CAUSE_SYS;
    else                sel_cause = CAUSE_IRQ_BASE + 5'(irq_idx);
  end

  // A serviced line is cleared in SAVE; a new edge in the same cycle re-sets it.
  always_comb begin
    clr_mask = '0;
    if (state_q == StSave && cause_q >= CAUSE_IRQ_BASE) clr_mask[cause_q[IdxW-1:0]] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | irq_edge;
  end

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    write_epc_o   = 1'b0;
    write_cause_o = 1'b0;
    write_int_o   = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    int_en_o      = int_en_q;
    stall_o       = 1'b1;
    unique case (state_q)
      StIdle: begin
        stall_o = pc_valid_i & (exc | irq_any | eret_i);
        // eret outranks interrupts, so an irq is taken only without eret.
        if (pc_valid_i) begin
          if (exc || (!eret_i && irq_any)) begin
            capture = 1'b1;
            state_d = StSave;
          end else if (eret_i) begin
            state_d = StEret;
          end
        end
      end
      StSave: begin
        write_epc_o   = 1'b1;
        write_cause_o = 1'b1;
        write_int_o   = 1'b1;
        state_d       = StVector;
      end
      StVector: begin
        redirect_o    = 1'b1;
        redirect_pc_o = base_i + {24'b0, cause_q, 3'b000};
        state_d       = StIdle;
      end
      StEret: begin
        write_int_o   = 1'b1;
        int_en_o      = int_en_i | 32'h1;
        redirect_o    = 1'b1;
        redirect_pc_o = epc_i;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      int_en_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (capture) begin
        epc_q    <= pc_i;
        cause_q  <= sel_cause;
        int_en_q <= int_en_i & ~32'h1;
      end
    end
  end

  assign epc_pc_o = epc_q;
  assign cause_o  = cause_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        ill_exc_i, sys_exc_i, eret_i;
  logic [31:0] int_en_i, base_i, epc_i;
  logic        write_epc_o, write_cause_o, write_int_o;
  logic [31:0] epc_pc_o;
  logic [4:0]  cause_o;
  logic [31:0] int_en_o;
  logic        stall_o, redirect_o, busy_o;
  logic [31:0] redirect_pc_o;

  interrupt_sequencer #(.NIRQ(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq_i),
    .pc_valid_i    (pc_valid_i),
    .pc_i          (pc_i),
    .ill_exc_i     (ill_exc_i),
    .sys_exc_i     (sys_exc_i),
    .eret_i        (eret_i),
    .int_en_i      (int_en_i),
    .base_i        (base_i),
    .epc_i         (epc_i),
    .write_epc_o   (write_epc_o),
    .write_cause_o (write_cause_o),
    .write_int_o   (write_int_o),
    .epc_pc_o      (epc_pc_o),
    .cause_o       (cause_o),
    .int_en_o      (int_en_o),
    .stall_o       (stall_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending set, last three sampled irq values, and a queue of
  // upcoming sequence cycles (1 = save, 2 = vector, 3 = eret).
  logic [7:0]  m_pend, h1, h2, h3;
  logic [31:0] m_epc, m_inten;
  logic [4:0]  m_cause;
  int          sched[$];

  task automatic model_clear();
    m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
    m_epc = '0; m_inten = '0; m_cause = '0;
    sched.delete();
  endtask

  // Called during the low clock phase with inputs already applied; compares all
  // outputs, advances the model over the next rising edge, returns at negedge.
  task automatic step();
    int          ph, idx;
    logic        exc;
    logic [7:0]  elig;
    logic        e_we, e_wc, e_wi, e_rd, e_st;
    logic [31:0] e_rpc, e_ien;
    #1;
    ph   = (sched.size() == 0) ? 0 : sched[0];
    exc  = ill_exc_i | sys_exc_i;
    elig = m_pend & {8{int_en_i[0]}} & int_en_i[15:8];
    e_we = 0; e_wc = 0; e_wi = 0; e_rd = 0; e_st = 1; e_rpc = 0; e_ien = m_inten;
    case (ph)
      0: e_st = pc_valid_i & (exc | (elig != 0) | eret_i);
      1: begin e_we = 1; e_wc = 1; e_wi = 1; end
      2: begin e_rd = 1; e_rpc = base_i + 32'(m_cause) * 8; end
      default: begin e_wi = 1; e_rd = 1; e_rpc = epc_i; e_ien = int_en_i | 32'h1; end
    endcase
    check("write_epc", write_epc_o, e_we);
    check("write_cause", write_cause_o, e_wc);
    check("write_int", write_int_o, e_wi);
    check("redirect", redirect_o, e_rd);
    check("redirect_pc", redirect_pc_o, e_rpc);
    check("stall", stall_o, e_st);
    check("busy", busy_o, ph != 0);
    check("epc_pc", epc_pc_o, m_epc);
    check("cause", cause_o, m_cause);
    check("int_en_o", int_en_o, e_ien);

    if (ph == 1 && m_cause >= 5'd16) m_pend[m_cause - 5'd16] = 1'b0;
    m_pend = m_pend | (h2 & ~h3);
    h3 = h2; h2 = h1; h1 = irq_i;
    if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (pc_valid_i) begin
      if (exc || (!eret_i && elig != 0)) begin
        idx = 0;
        for (int i = 7; i >= 0; i--) if (elig[i]) idx = i;
        m_epc   = pc_i;
        m_cause = ill_exc_i ? 5'd10 : sys_exc_i ? 5'd8 : 5'(16 + idx);
        m_inten = int_en_i & ~32'h1;
        sched.push_back(1);
        sched.push_back(2);
      end else if (eret_i) begin
        sched.push_back(3);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    irq_i = '0; pc_valid_i = 0; pc_i = '0; ill_exc_i = 0; sys_exc_i = 0; eret_i = 0;
    int_en_i = '0; base_i = '0; epc_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_save(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step();
      if (write_epc_o) break;
    end
    check(tag, write_epc_o, 1);
  endtask

  initial begin
    do_reset();
    check("rst_busy", busy_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_strobes", {write_epc_o, write_cause_o, write_int_o, redirect_o}, 0);
    check("rst_epc", epc_pc_o, 0);
    check("rst_cause", cause_o, 0);
    check("rst_int_en", int_en_o, 0);
    check("rst_rpc", redirect_pc_o, 0);

    // irq0 entry and vector
    int_en_i = 32'h0000_0101; base_i = 32'h1000; pc_i = 32'h40; pc_valid_i = 1; irq_i = 8'h01;
    run_until_save(10, "irq0_reach_save");
    check("irq0_epc", epc_pc_o, 32'h40);
    check("irq0_cause", cause_o, 16);
    check("irq0_int_en", int_en_o, 32'h100);
    pc_valid_i = 0;
    step();
    check("irq0_redirect", redirect_o, 1);
    check("irq0_vector", redirect_pc_o, 32'h1080);
    step();

    // illegal beats syscall, taken with interrupts disabled
    do_reset();
    base_i = 32'h1000; pc_valid_i = 1; ill_exc_i = 1; sys_exc_i = 1; pc_i = 32'h200;
    step();
    check("ill_cause", cause_o, 10);
    ill_exc_i = 0; sys_exc_i = 0; pc_valid_i = 0;
    step();
    check("ill_vector", redirect_pc_o, 32'h1050);
    pc_valid_i = 1;
    repeat (3) step();
    check("sys_dropped", busy_o, 0);

    // lines 3 and 5: lowest first, then 5 after eret re-enables
    do_reset();
    int_en_i = 32'h2801; base_i = 32'h1000; pc_valid_i = 1; irq_i = 8'h28;
    run_until_save(10, "irq3_reach_save");
    check("irq3_cause", cause_o, 19);
    step();
    int_en_i = 32'h2800;
    repeat (3) step();
    check("gie_off_no_take", busy_o, 0);
    eret_i = 1; epc_i = 32'h80;
    step();
    check("eret35_int_en", int_en_o, 32'h2801);
    eret_i = 0; int_en_i = 32'h2801;
    run_until_save(4, "irq5_reach_save");
    check("irq5_cause", cause_o, 21);
    repeat (2) step();

    // masked line held pending, then taken once unmasked
    do_reset();
    int_en_i = 32'h0001; pc_valid_i = 1; irq_i = 8'h04;
    repeat (8) step();
    check("masked_not_taken", busy_o, 0);
    int_en_i = 32'h0401;
    step();
    check("unmasked_taken", write_epc_o, 1);
    check("unmasked_cause", cause_o, 18);
    repeat (2) step();

    // eret alone
    do_reset();
    int_en_i = 32'h100; epc_i = 32'h44; pc_valid_i = 1; eret_i = 1;
    step();
    eret_i = 0; pc_valid_i = 0;
    check("eret_write_int", write_int_o, 1);
    check("eret_int_en", int_en_o, 32'h101);
    check("eret_rpc", redirect_pc_o, 32'h44);
    check("eret_redirect", redirect_o, 1);
    step();
    check("eret_back_idle", busy_o, 0);

    // reset in SAVE
    do_reset();
    int_en_i = 32'h101; pc_valid_i = 1; irq_i = 8'h01;
    run_until_save(10, "rst_mid_reach_save");
    rst = 1; irq_i = 0;
    #1;
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_strobes", {write_epc_o, write_cause_o, write_int_o, redirect_o}, 0);
    model_clear();
    @(negedge clk);
    rst = 0;
    repeat (6) step();
    check("rst_mid_pending_lost", stall_o, 0);

    // randomized traffic
    do_reset();
    int_en_i = 32'h0000_ff01;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) irq_i[$urandom_range(7)] = ~irq_i[$urandom_range(7)];
      if ($urandom_range(15) == 0) irq_i = irq_i ^ 8'($urandom);
      if ($urandom_range(31) == 0)
        int_en_i = {16'($urandom), 8'($urandom), 7'($urandom), ($urandom_range(3) != 0)};
      pc_valid_i = ($urandom_range(1) == 0);
      pc_i       = $urandom;
      base_i     = $urandom;
      epc_i      = $urandom;
      ill_exc_i  = ($urandom_range(15) == 0);
      sys_exc_i  = ($urandom_range(15) == 0);
      eret_i     = ($urandom_range(9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
